// File: rtl/text_render_hl.sv
// ============================================================================
// Module : text_render_hl
// Text-mode LCD pixel renderer: scans the raster, fetches glyph rows and
// drives RGB with a cursor-cell highlight (inverse, colour, blink-inverse).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module text_render_hl #(
    parameter int          H_ACTIVE     = 480,
    parameter int          V_ACTIVE     = 272,
    parameter int          GLYPH_W      = 8,
    parameter int          GLYPH_H      = 16,
    parameter int          COLOR_W      = 8,
    parameter int          MEM_LAT      = 2,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] HL_COLOR     = 24'hFFFF00,
    localparam int         COLS         = H_ACTIVE / GLYPH_W,
    localparam int         ROWS         = V_ACTIVE / GLYPH_H,
    localparam int         XW           = $clog2(H_ACTIVE),
    localparam int         YW           = $clog2(V_ACTIVE),
    localparam int         CW           = $clog2(COLS),
    localparam int         RW           = $clog2(ROWS + 1),
    localparam int         GRW          = $clog2(GLYPH_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 valid_region,
    input  logic                 v_blank,
    input  logic [CW-1:0]        cursor_x,
    input  logic [RW-1:0]        cursor_y,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] fg_rgb,
    input  logic [3*COLOR_W-1:0] bg_rgb,
    output logic [CW+RW-1:0]     char_addr,
    output logic [GRW-1:0]       glyph_row,
    input  logic [GLYPH_W-1:0]   glyph_bits,
    output logic [COLOR_W-1:0]   value_red,
    output logic [COLOR_W-1:0]   value_green,
    output logic [COLOR_W-1:0]   value_blue,
    output logic                 pix_valid,
    output logic [XW-1:0]        x_pos,
    output logic [YW-1:0]        y_pos
);

    localparam int GWB  = $clog2(GLYPH_W);
    localparam int GHB  = $clog2(GLYPH_H);
    localparam int FCW  = $clog2(BLINK_FRAMES + 1);
    localparam int RGBW = 3 * COLOR_W;

    // Highlight colour channels live in the top COLOR_W bits of each byte.
    localparam logic [RGBW-1:0] HL_RGB = {HL_COLOR[23 -: COLOR_W],
                                          HL_COLOR[15 -: COLOR_W],
                                          HL_COLOR[7  -: COLOR_W]};

    typedef struct packed {
        logic            valid;
        logic            active;
        logic            hl;
        logic [1:0]      md;
        logic [GWB-1:0]  bidx;
        logic [RGBW-1:0] fg;
        logic [RGBW-1:0] bg;
    } side_t;

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              vb_q;
    logic [FCW-1:0]    fc_q, fc_d;
    logic              blink_q, blink_d;
    logic [CW+RW-1:0]  ca_q;
    logic [GRW-1:0]    gr_q;
    side_t             side_q [0:MEM_LAT];
    side_t             side_d;
    logic [RGBW-1:0]   rgb_q, rgb_d;
    logic              pv_q, pv_d;

    logic              vb_rise;
    logic [CW-1:0]     cell_col;
    logic [RW-1:0]     cell_row;
    logic              hit;
    side_t             last;
    logic              pbit;
    logic              col_hl;
    logic              qbit;

    always_comb begin
        vb_rise = v_blank & ~vb_q;
        x_d     = x_q;
        y_d     = y_q;
        fc_d    = fc_q;
        blink_d = blink_q;
        if (vb_rise) begin
            x_d = '0;
            y_d = '0;
            if (fc_q == FCW'(BLINK_FRAMES - 1)) begin
                fc_d    = '0;
                blink_d = ~blink_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end else if (valid_region) begin
            if (x_q == XW'(H_ACTIVE - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Stage 0 of the side pipeline: everything the colour stage needs is
    // captured alongside the address so in-flight pixels ignore later changes.
    always_comb begin
        cell_col      = CW'(x_q >> GWB);
        cell_row      = RW'(y_q >> GHB);
        hit           = (cell_col == cursor_x) && (cell_row == cursor_y);
        side_d        = '0;
        side_d.valid  = valid_region & en;
        side_d.active = valid_region;
        side_d.hl     = hit & ((mode == 2'd1) | (mode == 2'd2) |
                               ((mode == 2'd3) & blink_q));
        side_d.md     = mode;
        side_d.bidx   = x_q[GWB-1:0];
        side_d.fg     = fg_rgb;
        side_d.bg     = bg_rgb;
    end

    always_comb begin
        last   = side_q[MEM_LAT];
        pbit   = glyph_bits[GWB'(GLYPH_W - 1) - last.bidx];
        col_hl = last.hl & (last.md == 2'd2);
        qbit   = pbit ^ (last.hl & (last.md != 2'd2));
        rgb_d  = '0;
        pv_d   = last.active;
        if (last.valid) begin
            if (col_hl) begin
                rgb_d = pbit ? HL_RGB : last.bg;
            end else begin
                rgb_d = qbit ? last.fg : last.bg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            vb_q    <= 1'b0;
            fc_q    <= '0;
            blink_q <= 1'b0;
            ca_q    <= '0;
            gr_q    <= '0;
            rgb_q   <= '0;
            pv_q    <= 1'b0;
            for (int i = 0; i <= MEM_LAT; i++) begin
                side_q[i] <= '0;
            end
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            vb_q      <= v_blank;
            fc_q      <= fc_d;
            blink_q   <= blink_d;
            ca_q      <= {cell_row, cell_col};
            gr_q      <= y_q[GHB-1:0];
            rgb_q     <= rgb_d;
            pv_q      <= pv_d;
            side_q[0] <= side_d;
            for (int i = 1; i <= MEM_LAT; i++) begin
                side_q[i] <= side_q[i-1];
            end
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign char_addr   = ca_q;
    assign glyph_row   = gr_q;
    assign value_red   = rgb_q[RGBW-1 -: COLOR_W];
    assign value_green = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign value_blue  = rgb_q[COLOR_W-1:0];
    assign pix_valid   = pv_q;

endmodule

`default_nettype wire
